multi_cycle_control_unit: RTL

Main control FSM of the multi-cycle RV32I core. It sequences each instruction through IF/ID/EX/MEM/WB and drives datapath enables and mux selects. It also drives alu_mode, which tells the downstream ALU control unit whether to force ADD, decode funct3/funct7, or perform a branch compare. It waits on a memory-ready handshake for instruction and data accesses, and stops permanently on an ECALL halt request.

---
 rtl/multi_cycle_control_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_control_unit.sv
// -----------------------------------------------------------------------------
// multi_cycle_control_unit
//
// Main control FSM of the multi-cycle RV32I core. It steps each instruction
// through IF/ID/EX/MEM/WB and drives the datapath enables and mux selects.
// It also tells the ALU control unit whether to force ADD, decode funct3/7,
// or do a branch compare. Instruction and data accesses wait on mem_ready.
// An ECALL with x17 == ECALL_HALT_CODE parks the core in HALT until reset.
//
// Ports:
//   clk            core clock, rising edge
//   reset_n        synchronous active-low reset
//   opcode         IR[6:0], stable from ID to end of instruction
//   x17_value      current x17, used for the ECALL halt check
//   mem_ready      memory completes the current access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if ALU branch result is true
//   pc_source      0 = ALU result, 1 = ALUOut
//   i_or_d         memory address: 0 = PC, 1 = ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       latch IR and old_pc
//   reg_write      register file write
//   mem_to_reg     rd source: 0 = ALUOut, 1 = MDR, 2 = old_pc+4
//   alu_src_a      0 = PC, 1 = A reg, 2 = old_pc
//   alu_src_b      0 = B reg, 1 = const 4, 2 = imm
//   alu_mode       0 = force ADD, 1 = decode funct, 2 = branch compare
//   is_halted      core halted (sticky until reset)
//   state_out      current state for debug
// -----------------------------------------------------------------------------
module multi_cycle_control_unit #(
    parameter logic [31:0] ECALL_HALT_CODE = 32'd10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  opcode,
    input  logic [31:0] x17_value,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_source,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_mode,
    output logic        is_halted,
    output logic [2:0]  state_out
);

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    assign state_out = r_state;

    always_comb begin
        w_next        = r_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 2'd0;
        alu_src_a     = 2'd0;
        alu_src_b     = 2'd0;
        alu_mode      = 2'd0;
        is_halted     = 1'b0;

        case (r_state)
            S_IF: begin
                // PC <= PC + 4 and IR latch only on the cycle the fetch completes
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    w_next = S_ID;
                end
            end
            S_ID: begin
                // Precompute old_pc + imm into ALUOut as the branch/JAL target
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                w_next    = S_EX;
            end
            S_EX: begin
                case (opcode)
                    OP_ARITH: begin
                        alu_src_a = 2'd1;
                        alu_mode  = 2'd1;
                        w_next    = S_WB;
                    end
                    OP_ARITH_IMM: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd2;
                        alu_mode  = 2'd1;
                        w_next    = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd2;
                        w_next    = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a     = 2'd1;
                        alu_mode      = 2'd2;
                        pc_write_cond = 1'b1;
                        pc_source     = 1'b1;
                        w_next        = S_IF;
                    end
                    OP_JAL: begin
                        pc_write  = 1'b1;
                        pc_source = 1'b1;
                        w_next    = S_WB;
                    end
                    OP_JALR: begin
                        // rs1 + imm straight from the ALU; the datapath clears bit 0
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd2;
                        pc_write  = 1'b1;
                        w_next    = S_WB;
                    end
                    OP_ECALL: begin
                        w_next = (x17_value == ECALL_HALT_CODE) ? S_HALT : S_IF;
                    end
                    default: begin
                        w_next = S_IF;
                    end
                endcase
            end
            S_MEM: begin
                i_or_d = 1'b1;
                if (opcode == OP_LOAD) begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        w_next = S_WB;
                    end
                end else if (opcode == OP_STORE) begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        w_next = S_IF;
                    end
                end else begin
                    w_next = S_IF;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                if (opcode == OP_LOAD) begin
                    mem_to_reg = 2'd1;
                end else if (opcode == OP_JAL || opcode == OP_JALR) begin
                    mem_to_reg = 2'd2;
                end else begin
                    mem_to_reg = 2'd0;
                end
                w_next = S_IF;
            end
            S_HALT: begin
                is_halted = 1'b1;
            end
            default: begin
                w_next = S_IF;
            end
        endcase

        // Reset masks every side-effecting strobe so an aborted access
        // cannot complete while reset_n is low.
        if (!reset_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            is_halted     = 1'b0;
        end
    end

endmodule
